// File: rtl/pipe_xfer_reg_if.sv
// Bundle of the pipeline-register payload, context and control signals.
// master = stage controller / upstream side, slave = the register itself.
interface pipe_xfer_reg_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int PERF_W  = 16
);
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic                in_valid;
    logic [ADDR_W-1:0]   in_waddr;
    logic [DATA_W-1:0]   in_wdata;
    logic                in_wreg;
    logic                in_whilo;
    logic [DATA_W-1:0]   in_hi;
    logic [DATA_W-1:0]   in_lo;
    logic [CNT_W-1:0]    cnt_i;
    logic [2*DATA_W-1:0] temp_i;
    logic                out_valid;
    logic [ADDR_W-1:0]   out_waddr;
    logic [DATA_W-1:0]   out_wdata;
    logic                out_wreg;
    logic                out_whilo;
    logic [DATA_W-1:0]   out_hi;
    logic [DATA_W-1:0]   out_lo;
    logic [CNT_W-1:0]    cnt_o;
    logic [2*DATA_W-1:0] temp_o;
    logic [PERF_W-1:0]   bubble_cnt;
    logic [PERF_W-1:0]   hold_cnt;

    modport master (
        output stall, flush, in_valid, in_waddr, in_wdata, in_wreg,
               in_whilo, in_hi, in_lo, cnt_i, temp_i,
        input  out_valid, out_waddr, out_wdata, out_wreg, out_whilo,
               out_hi, out_lo, cnt_o, temp_o, bubble_cnt, hold_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_waddr, in_wdata, in_wreg,
               in_whilo, in_hi, in_lo, cnt_i, temp_i,
        output out_valid, out_waddr, out_wdata, out_wreg, out_whilo,
               out_hi, out_lo, cnt_o, temp_o, bubble_cnt, hold_cnt
    );
endinterface

// File: rtl/pipe_xfer_reg.sv
// Inter-stage pipeline register with flush/bubble/hold and multi-cycle context return.
// Optional stall-event counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_xfer_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int PERF_W  = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_xfer_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_e;

    act_e                act_s;
    logic                up_s;
    logic                dn_s;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wreg_q,  wreg_d;
    logic                whilo_q, whilo_d;
    logic [DATA_W-1:0]   hi_q,    hi_d;
    logic [DATA_W-1:0]   lo_q,    lo_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [2*DATA_W-1:0] temp_q,  temp_d;

    assign up_s = bus.stall[STAGE];
    assign dn_s = bus.stall[STAGE+1];

    // Action selection; a stalled downstream with a running upstream still advances.
    always_comb begin
        act_s = ACT_ADVANCE;
        if (bus.flush) begin
            act_s = ACT_FLUSH;
        end else if (up_s && !dn_s) begin
            act_s = ACT_BUBBLE;
        end else if (up_s) begin
            act_s = ACT_HOLD;
        end else begin
            act_s = ACT_ADVANCE;
        end
    end

    // Next-state of payload and context for the selected action.
    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wreg_d  = wreg_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        case (act_s)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                waddr_d = {ADDR_W{1'b0}};
                wdata_d = {DATA_W{1'b0}};
                wreg_d  = 1'b0;
                whilo_d = 1'b0;
                hi_d    = {DATA_W{1'b0}};
                lo_d    = {DATA_W{1'b0}};
                if (act_s == ACT_BUBBLE) begin
                    cnt_d  = bus.cnt_i;
                    temp_d = bus.temp_i;
                end else begin
                    cnt_d  = {CNT_W{1'b0}};
                    temp_d = {(2*DATA_W){1'b0}};
                end
            end
            ACT_ADVANCE: begin
                valid_d = bus.in_valid;
                waddr_d = bus.in_waddr;
                wdata_d = bus.in_wdata;
                wreg_d  = bus.in_wreg;
                whilo_d = bus.in_whilo;
                hi_d    = bus.in_hi;
                lo_d    = bus.in_lo;
                cnt_d   = {CNT_W{1'b0}};
                temp_d  = {(2*DATA_W){1'b0}};
            end
            ACT_HOLD: begin
                cnt_d  = bus.cnt_i;
                temp_d = bus.temp_i;
            end
            default: begin
                cnt_d  = {CNT_W{1'b0}};
                temp_d = {(2*DATA_W){1'b0}};
            end
        endcase
    end

    // Payload and context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            waddr_q <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wreg_q  <= 1'b0;
            whilo_q <= 1'b0;
            hi_q    <= {DATA_W{1'b0}};
            lo_q    <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            temp_q  <= {(2*DATA_W){1'b0}};
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_waddr = waddr_q;
    assign bus.out_wdata = wdata_q;
    assign bus.out_wreg  = wreg_q;
    assign bus.out_whilo = whilo_q;
    assign bus.out_hi    = hi_q;
    assign bus.out_lo    = lo_q;
    assign bus.cnt_o     = cnt_q;
    assign bus.temp_o    = temp_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    logic [PERF_W-1:0] bubble_q, bubble_d;
    logic [PERF_W-1:0] hold_q,   hold_d;

    // Saturating event counters; flush never selects BUBBLE/HOLD so it is not counted.
    always_comb begin
        bubble_d = bubble_q;
        hold_d   = hold_q;
        if ((act_s == ACT_BUBBLE) && (bubble_q != PERF_MAX)) begin
            bubble_d = bubble_q + PERF_W'(1);
        end else begin
            bubble_d = bubble_q;
        end
        if ((act_s == ACT_HOLD) && (hold_q != PERF_MAX)) begin
            hold_d = hold_q + PERF_W'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= {PERF_W{1'b0}};
            hold_q   <= {PERF_W{1'b0}};
        end else begin
            bubble_q <= bubble_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.bubble_cnt = bubble_q;
    assign bus.hold_cnt   = hold_q;
`else
    assign bus.bubble_cnt = {PERF_W{1'b0}};
    assign bus.hold_cnt   = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_xfer_reg.sv
// Directed vector table, hand-written corner sequences and a randomized model comparison
// for pipe_xfer_reg (a 16-bit and a 2-bit perf-counter instance share the same stimulus).
module tb_pipe_xfer_reg;
    typedef struct {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        logic        valid;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wreg;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  cnt;
        logic [63:0] temp;
    } in_t;

    typedef struct {
        logic        valid;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wreg;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  cnt;
        logic [63:0] temp;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
        int   bub;
        int   hold;
    } vec_t;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipe_xfer_reg_if #(.PERF_W(16)) ifm ();
    pipe_xfer_reg_if #(.PERF_W(2))  ifs ();

    assign ifs.stall    = ifm.stall;
    assign ifs.flush    = ifm.flush;
    assign ifs.in_valid = ifm.in_valid;
    assign ifs.in_waddr = ifm.in_waddr;
    assign ifs.in_wdata = ifm.in_wdata;
    assign ifs.in_wreg  = ifm.in_wreg;
    assign ifs.in_whilo = ifm.in_whilo;
    assign ifs.in_hi    = ifm.in_hi;
    assign ifs.in_lo    = ifm.in_lo;
    assign ifs.cnt_i    = ifm.cnt_i;
    assign ifs.temp_i   = ifm.temp_i;

    pipe_xfer_reg #(.PERF_W(16)) u_main (.clk(clk), .rst(rst), .bus(ifm));
    pipe_xfer_reg #(.PERF_W(2))  u_sat  (.clk(clk), .rst(rst), .bus(ifs));

    function automatic logic [63:0] exp_perf(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (!PERF_ON) return 64'd0;
        return 64'(raw > mx ? mx : raw);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input in_t v);
        rst          = v.rst;
        ifm.flush    = v.flush;
        ifm.stall    = v.stall;
        ifm.in_valid = v.valid;
        ifm.in_waddr = v.waddr;
        ifm.in_wdata = v.wdata;
        ifm.in_wreg  = v.wreg;
        ifm.in_whilo = v.whilo;
        ifm.in_hi    = v.hi;
        ifm.in_lo    = v.lo;
        ifm.cnt_i    = v.cnt;
        ifm.temp_i   = v.temp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input out_t e, input int bub, input int hold);
        chk({tag, ".valid"}, 64'(ifm.out_valid), 64'(e.valid));
        chk({tag, ".waddr"}, 64'(ifm.out_waddr), 64'(e.waddr));
        chk({tag, ".wdata"}, 64'(ifm.out_wdata), 64'(e.wdata));
        chk({tag, ".wreg"},  64'(ifm.out_wreg),  64'(e.wreg));
        chk({tag, ".whilo"}, 64'(ifm.out_whilo), 64'(e.whilo));
        chk({tag, ".hi"},    64'(ifm.out_hi),    64'(e.hi));
        chk({tag, ".lo"},    64'(ifm.out_lo),    64'(e.lo));
        chk({tag, ".cnt"},   64'(ifm.cnt_o),     64'(e.cnt));
        chk({tag, ".temp"},  ifm.temp_o,         e.temp);
        chk({tag, ".bub16"}, 64'(ifm.bubble_cnt), exp_perf(bub, 16));
        chk({tag, ".hold16"}, 64'(ifm.hold_cnt), exp_perf(hold, 16));
        chk({tag, ".bub2"},  64'(ifs.bubble_cnt), exp_perf(bub, 2));
        chk({tag, ".hold2"}, 64'(ifs.hold_cnt),  exp_perf(hold, 2));
        chk({tag, ".sat_valid"}, 64'(ifs.out_valid), 64'(e.valid));
        chk({tag, ".sat_cnt"},   64'(ifs.cnt_o),     64'(e.cnt));
    endtask

    // Behavioural reference: one edge of the pipeline register by action priority.
    out_t m;
    int   m_bub;
    int   m_hold;
    task automatic model_step(input in_t v);
        out_t z;
        z = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 64'd0};
        if (v.rst) begin
            m = z; m_bub = 0; m_hold = 0;
        end else if (v.flush) begin
            m = z;
        end else if (!v.stall[3]) begin
            m = '{v.valid, v.waddr, v.wdata, v.wreg, v.whilo, v.hi, v.lo, 2'd0, 64'd0};
        end else if (!v.stall[4]) begin
            m = z; m.cnt = v.cnt; m.temp = v.temp; m_bub++;
        end else begin
            m.cnt = v.cnt; m.temp = v.temp; m_hold++;
        end
    endtask

    vec_t tbl[14];
    out_t zero_o;
    in_t  iv;

    initial begin
        zero_o = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 64'd0};
        tbl[0] = '{'{1'b1, 1'b1, 6'h3f, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h1, 32'h2, 2'd3, 64'hFF},
                   zero_o, 0, 0};
        tbl[1] = '{'{1'b0, 1'b0, 6'h00, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h11, 32'h22, 2'd3, 64'h99},
                   '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h11, 32'h22, 2'd0, 64'd0}, 0, 0};
        tbl[2] = '{'{1'b0, 1'b0, 6'h08, 1'b1, 5'd7, 32'hAAAA, 1'b1, 1'b0, 32'h0, 32'h0, 2'd1, 64'h0000_0001_0000_0002},
                   '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd1, 64'h0000_0001_0000_0002}, 1, 0};
        tbl[3] = '{'{1'b0, 1'b0, 6'h00, 1'b1, 5'd9, 32'h1234, 1'b1, 1'b0, 32'h0, 32'h0, 2'd1, 64'h5},
                   '{1'b1, 5'd9, 32'h1234, 1'b1, 1'b0, 32'd0, 32'd0, 2'd0, 64'd0}, 1, 0};
        for (int k = 0; k < 3; k++)
            tbl[4+k] = '{'{1'b0, 1'b0, 6'h18, 1'b1, 5'd3, 32'h5555, 1'b0, 1'b1, 32'h7, 32'h8, 2'd2, 64'hAB},
                         '{1'b1, 5'd9, 32'h1234, 1'b1, 1'b0, 32'd0, 32'd0, 2'd2, 64'hAB}, 1, k + 1};
        tbl[7] = '{'{1'b0, 1'b1, 6'h08, 1'b1, 5'd3, 32'h66, 1'b1, 1'b1, 32'h1, 32'h1, 2'd2, 64'hCD},
                   zero_o, 1, 3};
        tbl[8] = '{'{1'b0, 1'b0, 6'h10, 1'b1, 5'd4, 32'h77, 1'b1, 1'b0, 32'h0, 32'h0, 2'd3, 64'hEE},
                   '{1'b1, 5'd4, 32'h77, 1'b1, 1'b0, 32'd0, 32'd0, 2'd0, 64'd0}, 1, 3};
        for (int k = 0; k < 5; k++) begin
            tbl[9+k] = '{'{1'b0, 1'b0, 6'h08, 1'b1, 5'd1, 32'h1, 1'b1, 1'b1, 32'h1, 32'h1, 2'(k), 64'(k * 3)},
                         zero_o, 2 + k, 3};
            tbl[9+k].e.cnt  = 2'(k);
            tbl[9+k].e.temp = 64'(k * 3);
        end

        drive(tbl[0].i);
        #2;
        for (int r = 0; r < 14; r++) begin
            drive(tbl[r].i);
            step();
            compare($sformatf("vec%0d", r), tbl[r].e, tbl[r].bub, tbl[r].hold);
        end

        // Reset in the middle of a multi-cycle op discards the context.
        iv = '{1'b0, 1'b0, 6'h08, 1'b1, 5'd2, 32'h9, 1'b1, 1'b0, 32'h0, 32'h0, 2'd1, 64'h1234_5678};
        drive(iv); step();
        chk("madd_cnt", 64'(ifm.cnt_o), 64'd1);
        iv.rst = 1'b1;
        drive(iv); step();
        compare("rst_mid", zero_o, 0, 0);

        // Five bubbles from reset: 16-bit counter reads 5, 2-bit counter saturates at 3.
        iv.rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(iv); step();
        end
        chk("bub5_main", 64'(ifm.bubble_cnt), PERF_ON ? 64'd5 : 64'd0);
        chk("bub5_sat",  64'(ifs.bubble_cnt), PERF_ON ? 64'd3 : 64'd0);

        // Randomized run against the reference model, starting from reset.
        iv.rst = 1'b1;
        drive(iv); model_step(iv); step();
        for (int n = 0; n < 400; n++) begin
            int sel;
            iv.rst   = ($urandom_range(0, 39) == 0);
            iv.flush = ($urandom_range(0, 9) == 0);
            iv.stall = 6'($urandom);
            sel      = int'($urandom_range(0, 3));
            iv.stall[3] = (sel == 1) || (sel == 2);
            iv.stall[4] = (sel == 2) || (sel == 3);
            iv.valid = 1'($urandom);
            iv.waddr = 5'($urandom);
            iv.wdata = $urandom;
            iv.wreg  = 1'($urandom);
            iv.whilo = 1'($urandom);
            iv.hi    = $urandom;
            iv.lo    = $urandom;
            iv.cnt   = 2'($urandom);
            iv.temp  = {$urandom, $urandom};
            drive(iv);
            model_step(iv);
            step();
            compare($sformatf("rnd%0d", n), m, m_bub, m_hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
